// File: rtl/exc_req_unit_if.sv
// Pipeline/CP0 signal bundle for exc_req_unit: M-stage trap inputs, mtc0/mfc0 port,
// interrupt lines, and the redirect/EPC outputs.
interface exc_req_unit_if;
    logic [31:0] pc_m;
    logic        bd_m;
    logic [4:0]  exc_code_m;
    logic [5:0]  hw_int;
    logic        we;
    logic [4:0]  addr;
    logic [31:0] wdata;
    logic        eret_m;
    logic        req;
    logic [31:0] epc_out;
    logic [31:0] rdata;

    modport master (
        output pc_m, bd_m, exc_code_m, hw_int, we, addr, wdata, eret_m,
        input  req, epc_out, rdata
    );

    modport slave (
        input  pc_m, bd_m, exc_code_m, hw_int, we, addr, wdata, eret_m,
        output req, epc_out, rdata
    );
endinterface

// File: rtl/exc_req_unit.sv
// CP0 exception/interrupt request unit: SR, Cause, EPC and the trap redirect request.
// Optional macro CP0_PRID_EN adds a read-only PRId register at addr 15.
module exc_req_unit (
    input  logic           clk,
    input  logic           reset,
    exc_req_unit_if.slave  bus
);
    localparam logic [4:0] ADDR_SR    = 5'd12;
    localparam logic [4:0] ADDR_CAUSE = 5'd13;
    localparam logic [4:0] ADDR_EPC   = 5'd14;
`ifdef CP0_PRID_EN
    localparam logic [4:0]  ADDR_PRID = 5'd15;
    localparam logic [31:0] PRID_VAL  = 32'h0000_1234;
`endif

    logic [5:0]  im;
    logic        exl;
    logic        ie;
    logic        bd;
    logic [5:0]  ip;
    logic [4:0]  exc_code;
    logic [29:0] epc_hi;

    logic        int_req;
    logic        exc_req;
    logic [31:0] trap_pc;

    assign int_req = (|(bus.hw_int & im)) & ie & ~exl;
    assign exc_req = (bus.exc_code_m != 5'd0) & ~exl;
    // Gate with reset so a pending M-stage exception cannot raise req while held in reset.
    assign bus.req = (int_req | exc_req) & reset;
    assign trap_pc = bus.bd_m ? (bus.pc_m - 32'd4) : bus.pc_m;
    assign bus.epc_out = {epc_hi, 2'b00};

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            im       <= 6'd0;
            exl      <= 1'b0;
            ie       <= 1'b0;
            bd       <= 1'b0;
            ip       <= 6'd0;
            exc_code <= 5'd0;
            epc_hi   <= 30'd0;
        end else begin
            ip <= bus.hw_int;
            if (bus.req) begin
                exl      <= 1'b1;
                bd       <= bus.bd_m;
                epc_hi   <= trap_pc[31:2];
                exc_code <= int_req ? 5'd0 : bus.exc_code_m;
            end else if (bus.eret_m) begin
                exl <= 1'b0;
            end else if (bus.we) begin
                if (bus.addr == ADDR_SR) begin
                    im  <= bus.wdata[15:10];
                    exl <= bus.wdata[1];
                    ie  <= bus.wdata[0];
                end else if (bus.addr == ADDR_EPC) begin
                    epc_hi <= bus.wdata[31:2];
                end
            end
        end
    end

    always_comb begin
        bus.rdata = 32'd0;
        case (bus.addr)
            ADDR_SR:    bus.rdata = {16'd0, im, 8'd0, exl, ie};
            ADDR_CAUSE: bus.rdata = {bd, 15'd0, ip, 3'd0, exc_code, 2'd0};
            ADDR_EPC:   bus.rdata = {epc_hi, 2'b00};
`ifdef CP0_PRID_EN
            ADDR_PRID:  bus.rdata = PRID_VAL;
`endif
            default:    bus.rdata = 32'd0;
        endcase
    end
endmodule

// File: tb/tb_exc_req_unit.sv
// Directed-vector bench for exc_req_unit: trap entry, eret, mtc0 precedence and async reset.
module tb_exc_req_unit;
    logic clk;
    logic reset;
    int   n_checks;
    int   n_pass;

    exc_req_unit_if bus ();

    exc_req_unit dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

`ifdef CP0_PRID_EN
    localparam logic [31:0] PRID_EXP = 32'h0000_1234;
`else
    localparam logic [31:0] PRID_EXP = 32'h0000_0000;
`endif

    initial begin
        clk = 1'b0;
        forever #10 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    endtask

    task automatic rd(input logic [4:0] a, input logic [31:0] exp, input string tag);
        bus.addr = a;
        #1;
        check(tag, bus.rdata, exp);
    endtask

    task automatic chk_req(input logic exp, input string tag);
        #1;
        check(tag, {31'd0, bus.req}, {31'd0, exp});
    endtask

    task automatic step;
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        n_checks = 0;
        n_pass   = 0;
        reset          = 1'b0;
        bus.pc_m       = 32'd0;
        bus.bd_m       = 1'b0;
        bus.exc_code_m = 5'd4;
        bus.hw_int     = 6'h3F;
        bus.we         = 1'b0;
        bus.addr       = 5'd0;
        bus.wdata      = 32'd0;
        bus.eret_m     = 1'b0;

        // Held in reset with a pending exception: req forced low, all regs read 0
        #3;
        chk_req(1'b0, "rst_req");
        rd(5'd12, 32'h0, "rst_sr");
        rd(5'd13, 32'h0, "rst_cause");
        rd(5'd14, 32'h0, "rst_epc");
        check("rst_epc_out", bus.epc_out, 32'h0);
        rd(5'd15, PRID_EXP, "rst_prid");

        @(negedge clk);
        reset          = 1'b1;
        bus.exc_code_m = 5'd0;
        bus.hw_int     = 6'd0;

        // mtc0 SR = 0x401 (IM0, IE); read shows pre-edge value
        bus.we    = 1'b1;
        bus.wdata = 32'h0000_0401;
        rd(5'd12, 32'h0, "sr_no_bypass");
        step;
        bus.we = 1'b0;
        rd(5'd12, 32'h0000_0401, "sr_written");

        // Interrupt on IP0
        bus.hw_int = 6'b000001;
        bus.pc_m   = 32'h0000_3010;
        chk_req(1'b1, "int_req");
        step;
        chk_req(1'b0, "int_req_drop");
        check("int_epc", bus.epc_out, 32'h0000_3010);
        rd(5'd12, 32'h0000_0403, "int_sr_exl");
        rd(5'd13, 32'h0000_0400, "int_cause");

        // eret clears EXL, pending interrupt re-requests
        bus.eret_m = 1'b1;
        chk_req(1'b0, "eret_cycle_req");
        step;
        bus.eret_m = 1'b0;
        chk_req(1'b1, "post_eret_req");
        bus.hw_int = 6'd0;
        chk_req(1'b0, "int_released");
        step;

        // Exception in a delay slot
        bus.exc_code_m = 5'd4;
        bus.bd_m       = 1'b1;
        bus.pc_m       = 32'h0000_3024;
        chk_req(1'b1, "exc_req");
        step;
        bus.exc_code_m = 5'd0;
        bus.bd_m       = 1'b0;
        check("exc_epc_bd", bus.epc_out, 32'h0000_3020);
        rd(5'd13, 32'h8000_0010, "exc_cause");
        rd(5'd12, 32'h0000_0403, "exc_sr");

        // EXL suppresses everything
        bus.exc_code_m = 5'd10;
        bus.hw_int     = 6'h3F;
        chk_req(1'b0, "exl_suppress");
        step;
        bus.eret_m = 1'b1;
        chk_req(1'b0, "exl_suppress_eret");
        step;
        bus.eret_m = 1'b0;
        rd(5'd12, 32'h0000_0401, "eret_sr");
        chk_req(1'b1, "eret_rearm");
        rd(5'd13, 32'h8000_FC10, "eret_cause_kept");
        bus.pc_m = 32'h0000_3040;
        step;
        // Interrupt wins over the simultaneous exception code
        bus.exc_code_m = 5'd0;
        bus.hw_int     = 6'd0;
        check("prio_epc", bus.epc_out, 32'h0000_3040);
        rd(5'd13, 32'h0000_FC00, "prio_cause");
        rd(5'd12, 32'h0000_0403, "prio_sr");

        // eret beats mtc0 SR
        bus.eret_m = 1'b1;
        bus.we     = 1'b1;
        bus.addr   = 5'd12;
        bus.wdata  = 32'h0;
        step;
        bus.eret_m = 1'b0;
        bus.we     = 1'b0;
        rd(5'd12, 32'h0000_0401, "eret_over_we");

        // req beats mtc0 EPC
        bus.exc_code_m = 5'd4;
        bus.pc_m       = 32'h0000_3050;
        bus.we         = 1'b1;
        bus.wdata      = 32'h0000_3007;
        rd(5'd14, 32'h0000_3040, "epc_no_bypass");
        chk_req(1'b1, "req_with_we");
        step;
        bus.exc_code_m = 5'd0;
        bus.we         = 1'b0;
        check("req_over_we", bus.epc_out, 32'h0000_3050);
        bus.eret_m = 1'b1;
        step;
        bus.eret_m = 1'b0;
        bus.we     = 1'b1;
        bus.addr   = 5'd14;
        bus.wdata  = 32'h0000_3007;
        step;
        bus.we = 1'b0;
        check("epc_we_masked", bus.epc_out, 32'h0000_3004);

        // Cause not writable; unimplemented address
        bus.we    = 1'b1;
        bus.addr  = 5'd13;
        bus.wdata = 32'hFFFF_FFFF;
        step;
        bus.we = 1'b0;
        rd(5'd13, 32'h0000_0010, "cause_ro");
        rd(5'd5, 32'h0, "unimpl_addr");

        // Async reset mid-handler
        bus.exc_code_m = 5'd4;
        bus.pc_m       = 32'h0000_3060;
        step;
        chk_req(1'b0, "handler_req");
        rd(5'd12, 32'h0000_0403, "handler_sr");
        #2;
        reset = 1'b0;
        chk_req(1'b0, "async_rst_req");
        rd(5'd12, 32'h0, "async_rst_sr");
        rd(5'd13, 32'h0, "async_rst_cause");
        rd(5'd14, 32'h0, "async_rst_epc");
        @(negedge clk);
        reset = 1'b1;
        chk_req(1'b1, "post_rst_exl_clear");
        #2;
        reset = 1'b0;
        chk_req(1'b0, "async_rst_live_req");
        @(negedge clk);
        reset          = 1'b1;
        bus.exc_code_m = 5'd0;
        rd(5'd15, PRID_EXP, "prid");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
